fetch_unit: RTL and testbench

- Instruction fetch front-end: issues word reads to a variable-latency instruction memory and buffers returned words in a small prefetch FIFO.
- Presents {instr, pc} pairs to the decode/execute core over a valid/ready handshake.
- Accepts redirects (taken branch/jump) from the core. On a redirect it flushes buffered words and discards responses still in flight for the old stream.
- Sits between the instruction memory and the decoder, replacing the direct PC-to-memory path.

---
 rtl/rv32_pkg.sv | 17 +
 rtl/fetch_unit_fifo.sv | 51 +++++
 rtl/fetch_unit.sv | 100 ++++++++++
 tb/tb_fetch_unit.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/rv32_pkg.sv
// Shared types and constants for the RV32 fetch front-end.
package rv32_pkg;

    localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;

    // Fetch addresses are always word aligned; the low two bits are dropped.
    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return addr & 32'hFFFF_FFFC;
    endfunction

endpackage

// File: rtl/fetch_unit_fifo.sv
// Prefetch buffer: DEPTH-entry synchronous FIFO of {pc, instr} pairs with flush.
module fetch_fifo
    import rv32_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  fetch_entry_t             wdata,
    input  logic                     pop,
    input  logic                     clear,
    output fetch_entry_t             rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);

    fetch_entry_t     mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    // A push into a full FIFO is only taken when the head leaves in the same cycle.
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    assign full  = (count == (AW+1)'(DEPTH));
    assign empty = (count == '0);
    assign rdata = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (!reset || clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch front-end: issues word reads, buffers replies, handles redirects
// by discarding responses that belong to the killed stream.
module fetch_unit
    import rv32_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
    parameter int          DEPTH    = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic        instr_valid,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    input  logic        instr_ready
);

    localparam int CW = $clog2(DEPTH) + 1;

    logic [31:0]   fetch_pc;
    logic [31:0]   rpc;
    logic [CW-1:0] out_cnt;
    logic [CW-1:0] drop_cnt;
    logic [CW-1:0] out_cnt_next;
    logic [CW-1:0] fifo_count;
    logic [CW:0]   claimed_slots;
    logic          run;
    logic          accept;
    logic          live_resp;
    logic          pop;
    logic          fifo_full;
    logic          fifo_empty;
    fetch_entry_t  head;

    // Slots already promised to the live stream: buffered words plus live in-flight reads.
    assign claimed_slots = {1'b0, fifo_count} + {1'b0, out_cnt} - {1'b0, drop_cnt};

    assign imem_req  = run && (out_cnt < CW'(DEPTH)) && (claimed_slots < (CW+1)'(DEPTH));
    assign imem_addr = fetch_pc;

    assign accept       = imem_req && imem_ready;
    assign live_resp    = imem_rvalid && (drop_cnt == '0) && !redirect_valid;
    assign pop          = instr_valid && instr_ready;
    assign out_cnt_next = out_cnt + CW'(accept) - CW'(imem_rvalid);

    assign instr_valid = !fifo_empty;
    assign instr       = instr_valid ? head.instr : NOP_INSTR;
    assign instr_pc    = instr_valid ? head.pc    : 32'h0;

    fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (live_resp),
        .wdata ('{pc: rpc, instr: imem_rdata}),
        .pop   (pop),
        .clear (redirect_valid),
        .rdata (head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    // On a redirect every read still in flight, including one accepted now, is stale.
    always_ff @(posedge clk) begin
        if (!reset) begin
            run      <= 1'b0;
            fetch_pc <= RESET_PC;
            rpc      <= RESET_PC;
            out_cnt  <= '0;
            drop_cnt <= '0;
        end else begin
            run     <= 1'b1;
            out_cnt <= out_cnt_next;
            if (redirect_valid) begin
                fetch_pc <= word_align(redirect_pc);
                rpc      <= word_align(redirect_pc);
                drop_cnt <= out_cnt_next;
            end else begin
                if (accept)    fetch_pc <= fetch_pc + 32'd4;
                if (live_resp) rpc      <= rpc + 32'd4;
                if (imem_rvalid && (drop_cnt != '0)) drop_cnt <= drop_cnt - 1'b1;
            end
        end
    end

    a_rvalid_needs_request: assert property (@(posedge clk) disable iff (!reset)
        !(imem_rvalid && (out_cnt == '0)))
        else $error("imem_rvalid with no outstanding request");

    a_no_overflow: assert property (@(posedge clk) disable iff (!reset)
        !(live_resp && fifo_full && !pop) && (out_cnt <= CW'(DEPTH)))
        else $error("prefetch buffer overflow or too many outstanding reads");

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed tables, corner sequences and a random run
// against a stream-level reference model.
module tb_fetch_unit;
    import rv32_pkg::*;

    localparam int          DEPTH   = 2;
    localparam logic [31:0] WRAP_PC = 32'hFFFF_FFF8;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready = 1'b0;
    logic        imem_rvalid = 1'b0;
    logic [31:0] imem_rdata = 32'h0;
    logic        instr_valid;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        instr_ready = 1'b0;

    logic        w_req;
    logic [31:0] w_addr;
    logic        w_rvalid = 1'b0;
    logic [31:0] w_rdata = 32'h0;
    logic        w_valid;
    logic [31:0] w_instr;
    logic [31:0] w_pc;

    always #5 clk = ~clk;

    fetch_unit #(.RESET_PC(32'h0), .DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .instr_valid(instr_valid), .instr(instr), .instr_pc(instr_pc),
        .instr_ready(instr_ready)
    );

    fetch_unit #(.RESET_PC(WRAP_PC), .DEPTH(DEPTH)) u_wrap (
        .clk(clk), .reset(reset),
        .redirect_valid(1'b0), .redirect_pc(32'h0),
        .imem_req(w_req), .imem_addr(w_addr), .imem_ready(1'b1),
        .imem_rvalid(w_rvalid), .imem_rdata(w_rdata),
        .instr_valid(w_valid), .instr(w_instr), .instr_pc(w_pc),
        .instr_ready(1'b1)
    );

    function automatic logic [31:0] memword(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'hC3A5_5A3C;
    endfunction

    // Zero-wait memory for the wrap-around instance: answers the cycle after acceptance.
    always @(posedge clk) begin
        if (!reset) begin
            w_rvalid <= 1'b0;
        end else begin
            w_rvalid <= w_req;
            w_rdata  <= memword(w_addr);
        end
    end

    typedef struct {
        logic [31:0] addr;
        int          due;
    } req_t;

    typedef struct {
        logic        rdy;
        logic        exp_req;
        logic [31:0] exp_addr;
        logic        exp_valid;
        logic [31:0] exp_pc;
    } vec_t;

    req_t        pending[$];
    logic [31:0] got[$];
    logic [31:0] exp_next = 32'h0;
    int          cycle = 0;
    int          ready_pct = 100;
    int          lat_min = 1;
    int          lat_max = 1;
    bit          hold = 1'b0;
    int          n_compared = 0;
    int          n_mismatch = 0;

    logic        s_req, s_valid, sw_valid;
    logic [31:0] s_addr, s_instr, s_pc, sw_instr, sw_pc;

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        n_compared++;
        if (actual !== expected) begin
            n_mismatch++;
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    function automatic logic [31:0] gotAt(input int i);
        return (i < got.size()) ? got[i] : 32'hDEAD_BEEF;
    endfunction

    // One clock cycle: drive memory side, sample outputs, score deliveries, track requests.
    task automatic applyStimulus();
        req_t r;
        @(negedge clk);
        imem_ready = (int'($urandom_range(99)) < ready_pct);
        if (reset && !hold && pending.size() > 0 && pending[0].due <= cycle) begin
            imem_rvalid = 1'b1;
            imem_rdata  = memword(pending[0].addr);
        end else begin
            imem_rvalid = 1'b0;
            imem_rdata  = $urandom;
        end
        #1;
        s_req = imem_req;   s_addr = imem_addr;
        s_valid = instr_valid; s_instr = instr; s_pc = instr_pc;
        sw_valid = w_valid; sw_instr = w_instr; sw_pc = w_pc;
        if (reset) begin
            if (s_valid !== 1'b1) begin
                checkOutput("idle instr", s_instr, NOP_INSTR);
                checkOutput("idle pc", s_pc, 32'h0);
            end
            if (s_valid && instr_ready) begin
                checkOutput("stream pc", s_pc, exp_next);
                checkOutput("stream instr", s_instr, memword(s_pc));
                got.push_back(s_pc);
                exp_next = exp_next + 32'd4;
            end
        end
        @(posedge clk);
        if (!reset) begin
            pending.delete();
            exp_next = 32'h0;
        end else begin
            if (imem_rvalid) void'(pending.pop_front());
            if (s_req && imem_ready) begin
                r.addr = s_addr;
                r.due  = cycle + int'($urandom_range(lat_max, lat_min));
                pending.push_back(r);
            end
            checkOutput("outstanding bound", 32'(pending.size() <= DEPTH), 32'd1);
            if (redirect_valid) exp_next = redirect_pc & 32'hFFFF_FFFC;
        end
        cycle++;
        #1;
    endtask

    task automatic applyReset();
        reset = 1'b0;
        instr_ready = 1'b0;
        redirect_valid = 1'b0;
        hold = 1'b0;
        ready_pct = 100; lat_min = 1; lat_max = 1;
        repeat (3) applyStimulus();
        reset = 1'b1;
        got.delete();
    endtask

    vec_t vecs[11];

    initial begin
        // Steady state with DEPTH=2 and a one-cycle memory delivers two words every three cycles.
        vecs[0]  = '{1'b1, 1'b0, 32'h00, 1'b0, 32'h00};
        vecs[1]  = '{1'b1, 1'b1, 32'h00, 1'b0, 32'h00};
        vecs[2]  = '{1'b1, 1'b1, 32'h04, 1'b0, 32'h00};
        vecs[3]  = '{1'b1, 1'b0, 32'h08, 1'b1, 32'h00};
        vecs[4]  = '{1'b1, 1'b1, 32'h08, 1'b1, 32'h04};
        vecs[5]  = '{1'b1, 1'b1, 32'h0C, 1'b0, 32'h00};
        vecs[6]  = '{1'b1, 1'b0, 32'h10, 1'b1, 32'h08};
        vecs[7]  = '{1'b1, 1'b1, 32'h10, 1'b1, 32'h0C};
        vecs[8]  = '{1'b1, 1'b1, 32'h14, 1'b0, 32'h00};
        vecs[9]  = '{1'b1, 1'b0, 32'h18, 1'b1, 32'h10};
        vecs[10] = '{1'b1, 1'b1, 32'h18, 1'b1, 32'h14};

        $display("[TB] reset release and streaming (with wrap-around instance)");
        applyReset();
        for (int i = 0; i < 11; i++) begin
            instr_ready = vecs[i].rdy;
            applyStimulus();
            checkOutput($sformatf("t1[%0d] req", i), 32'(s_req), 32'(vecs[i].exp_req));
            checkOutput($sformatf("t1[%0d] addr", i), s_addr, vecs[i].exp_addr);
            checkOutput($sformatf("t1[%0d] valid", i), 32'(s_valid), 32'(vecs[i].exp_valid));
            checkOutput($sformatf("t1[%0d] pc", i), s_pc, vecs[i].exp_pc);
            checkOutput($sformatf("t1[%0d] instr", i), s_instr,
                        vecs[i].exp_valid ? memword(vecs[i].exp_pc) : NOP_INSTR);
            checkOutput($sformatf("t1[%0d] wrap valid", i), 32'(sw_valid), 32'(vecs[i].exp_valid));
            checkOutput($sformatf("t1[%0d] wrap pc", i), sw_pc,
                        vecs[i].exp_valid ? WRAP_PC + vecs[i].exp_pc : 32'h0);
            checkOutput($sformatf("t1[%0d] wrap instr", i), sw_instr,
                        vecs[i].exp_valid ? memword(WRAP_PC + vecs[i].exp_pc) : NOP_INSTR);
        end

        $display("[TB] backpressure");
        applyReset();
        instr_ready = 1'b0;
        repeat (12) applyStimulus();
        checkOutput("t2 valid held", 32'(s_valid), 32'd1);
        checkOutput("t2 head pc", s_pc, 32'h0);
        checkOutput("t2 req stalled", 32'(s_req), 32'd0);
        checkOutput("t2 nothing consumed", 32'(got.size()), 32'd0);
        instr_ready = 1'b1;
        repeat (8) applyStimulus();
        checkOutput("t2 pc0", gotAt(0), 32'h0);
        checkOutput("t2 pc1", gotAt(1), 32'h4);
        checkOutput("t2 pc2", gotAt(2), 32'h8);

        $display("[TB] redirect with two reads outstanding");
        applyReset();
        instr_ready = 1'b1;
        repeat (5) applyStimulus();
        hold = 1'b1;
        applyStimulus();
        checkOutput("t3 second req", 32'(s_req), 32'd1);
        checkOutput("t3 second addr", s_addr, 32'hC);
        redirect_valid = 1'b1; redirect_pc = 32'h100;
        applyStimulus();
        checkOutput("t3 req blocked", 32'(s_req), 32'd0);
        redirect_valid = 1'b0; hold = 1'b0;
        applyStimulus();
        checkOutput("t3 empty after redirect", 32'(s_valid), 32'd0);
        repeat (12) applyStimulus();
        checkOutput("t3 pc0", gotAt(0), 32'h0);
        checkOutput("t3 pc1", gotAt(1), 32'h4);
        checkOutput("t3 pc2", gotAt(2), 32'h100);
        checkOutput("t3 pc3", gotAt(3), 32'h104);

        $display("[TB] redirect with simultaneous response and pop");
        applyReset();
        instr_ready = 1'b1;
        repeat (6) applyStimulus();
        redirect_valid = 1'b1; redirect_pc = 32'h203;
        applyStimulus();
        checkOutput("t4 head popped", s_pc, 32'h8);
        redirect_valid = 1'b0;
        applyStimulus();
        checkOutput("t4 flushed", 32'(s_valid), 32'd0);
        checkOutput("t4 new req", 32'(s_req), 32'd1);
        checkOutput("t4 aligned addr", s_addr, 32'h200);
        repeat (10) applyStimulus();
        checkOutput("t4 pc2", gotAt(2), 32'h8);
        checkOutput("t4 pc3", gotAt(3), 32'h200);
        checkOutput("t4 pc4", gotAt(4), 32'h204);

        $display("[TB] random stalls and redirects");
        applyReset();
        ready_pct = 50; lat_min = 1; lat_max = 4;
        for (int i = 0; i < 3000; i++) begin
            instr_ready    = ($urandom_range(3) != 0);
            redirect_valid = ($urandom_range(39) == 0);
            redirect_pc    = $urandom;
            applyStimulus();
        end
        redirect_valid = 1'b0;
        checkOutput("t6 progress", 32'(got.size() >= 200), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatch);
        $finish;
    end

endmodule
